// File: rtl/upe_serial_rx32.sv
//------------------------------------------------------------------------------
// upe_serial_rx32 : oversampled single-wire framed word receiver, valid/ready out.
// Optional even-parity bit enabled by defining UPE_RX_PARITY_EN.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module upe_serial_rx32 #(
  parameter int BIT_PERIOD = 1251,
  parameter int WIDTH      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_MID      = CNT_W'(BIT_PERIOD / 2);
  localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(BIT_PERIOD - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, rx_s_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;
  logic               perr_q, perr_d;
`ifdef UPE_RX_PARITY_EN
  logic               par_q, par_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b0;
      rx_s_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
`ifdef UPE_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= rx_in;
      rx_s_q  <= sync1_q;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
`ifdef UPE_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    // A handshake retires the held word unless a fresh word reloads it below.
    valid_d = valid_q && !out_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    perr_d  = 1'b0;
`ifdef UPE_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (rx_s_q) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == C_MID) begin
          cnt_d = '0;
          if (rx_s_q) begin
            idx_d   = '0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == C_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s_q, shreg_q[WIDTH-1:1]};
          if (idx_q == C_IDX_LAST) begin
`ifdef UPE_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UPE_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == C_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s_q;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == C_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_s_q) begin
            ferr_d = 1'b1;
`ifdef UPE_RX_PARITY_EN
          end else if (^{shreg_q, par_q}) begin
            perr_d = 1'b1;
`endif
          end else if (!valid_q || out_ready) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign parity_err = perr_q;

endmodule

`default_nettype wire

// File: doc/upe_serial_rx32.md
Name: upe_serial_rx32

Overview:
- Single-wire serial word receiver; the receive end of the LED bit-serial output used by the multiplier demo benches.
- Oversamples one input pin at a fixed bit period, detects a framed word and assembles WIDTH bits LSB-first.
- Presents the word on a valid/ready interface, so multiplier operands (x1 = data[15:0], x2 = data[31:16]) can be loaded from outside the FPGA.

Parameters:
- BIT_PERIOD, 1251: clock cycles per serial bit (1251 at 10 kHz matches the LED bit rate); legal minimum 4.
- WIDTH, 32: data bits per frame.

Ports:
- clk  input  1  system clock (10 kHz SB_LFOSC on target).
- rst_n  input  1  asynchronous active-low reset.
- rx_in  input  1  serial line, asynchronous to clk; idle level 0.
- out_data  output  WIDTH  received word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 1.
- overrun  output  1  one-cycle pulse: a complete frame was dropped because out_valid was still high.
- parity_err  output  1  one-cycle pulse on parity mismatch (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): state IDLE; out_data=0, out_valid=0, frame_err=0, overrun=0, parity_err=0; counters=0; shift register=0.
- rx_in passes through a 2-flop synchronizer; all logic uses the synchronized bit rx_s. This adds 2 cycles of latency.
- Frame format: start bit 1, then WIDTH data bits LSB-first, then [parity bit if enabled], then stop bit 0. Each bit is BIT_PERIOD cycles long.
- Bit counter counts 0..BIT_PERIOD-1 and wraps to 0; mid = BIT_PERIOD/2 (integer division).
- IDLE: on rx_s=1, clear the counter and go to START.
- START: when the counter reaches mid, sample rx_s.
  - 1: reset the counter and go to DATA with bitidx=0.
  - 0: treat as a glitch and return to IDLE with no flags.
- DATA: sample once per full BIT_PERIOD, at counter=BIT_PERIOD-1, i.e. at the middle of each bit.
  - Shift the sample into shreg[WIDTH-1] with a right shift, so the first bit lands in bit 0 after WIDTH samples.
  - After sample WIDTH-1, go to PARITY (feature on) or STOP.
- PARITY (feature only): sample one bit, then go to STOP.
- STOP: sample at the bit middle, then return to IDLE on the same edge. Outcomes of the stop sample:
  - Sample 1: frame_err pulses; the word is discarded and out_valid is unchanged.
  - Sample 0 with parity bad (feature on): parity_err pulses; the word is discarded.
  - Sample 0 and good, out_valid=0 or out_valid && out_ready that cycle: out_data<=shreg and out_valid<=1 on the next edge.
  - Sample 0 and good, out_valid=1 && !out_ready: overrun pulses; the old word is retained and the new word dropped.
- Handshake:
  - out_valid && out_ready clears out_valid on the next edge, unless a new good word loads in the same cycle, in which case out_valid stays 1 with the new data.
  - out_data is stable while out_valid=1.
- Latency: out_valid rises 2 (sync) + 1 cycles after the stop-bit sample point.
- A rx_s=1 seen in IDLE on the cycle right after STOP starts a new frame, so back-to-back frames are supported.
- Async reset mid-frame aborts the frame; nothing is output; the receiver restarts in IDLE.
- Error pulses are mutually exclusive and last exactly one cycle.

Optional Feature:
- Macro UPE_RX_PARITY_EN.
- Defined: the frame carries one even-parity bit after the data (XOR of data bits and parity bit must be 0); PARITY state present; parity_err driven as described.
- Undefined: no parity bit in the frame, PARITY state absent, parity_err tied 0.

Test Plan:
- BIT_PERIOD=8; send frame 0x14551577 with idle gaps -> out_valid rises once, out_data=0x14551577, no error pulses; out_valid holds until out_ready=1, then drops next cycle.
- 3-cycle high glitch on rx_in in IDLE -> START rejects it, state returns to IDLE, no output and no flags.
- Send 0x00003953, then 0x00005ACD back-to-back, out_ready=1 -> two valid words in order with no gap lost.
- Send two frames with out_ready=0 -> first word 0x14551577 retained, overrun pulses once at end of second frame.
- Frame with stop bit forced to 1 -> frame_err one-cycle pulse, out_valid stays 0; next good frame received normally.
- Assert rst_n low at data bit 10 -> outputs 0 immediately; re-send 0xFFFFFFFF -> received correctly.
- With UPE_RX_PARITY_EN defined, send 0x00000001 with parity bit 0 -> parity_err pulse, word dropped; with parity bit 1 -> word accepted.
